// File: rtl/recorder_control.sv
// +----------------------------------------------------------------------+
// | recorder_control: record/playback FSM for a two-clip audio recorder. |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module recorder_control #(
  parameter int OFFSET_W = 14
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [4:0]          sync,
  input  logic                sample_tick,
  output logic [OFFSET_W:0]   mem_addr,
  output logic                mem_we,
  output logic                mem_re,
  output logic                recording,
  output logic                playing,
  output logic                done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REC  = 2'd1;
  localparam logic [1:0] PLAY = 2'd2;

  logic                soft_clear;
  logic                rec_btn;
  logic                play_btn;
  logic                clip_wr;
  logic                clip_rd;

  logic                prev_rec;
  logic                prev_play;
  logic                rec_edge;
  logic                play_edge;

  logic [1:0]          state;
  logic                cur_clip;
  logic [OFFSET_W-1:0] offset;
  logic [OFFSET_W:0]   len [2];

  logic [OFFSET_W:0]   offset_next;
  logic [OFFSET_W:0]   len_entry;
  logic [OFFSET_W:0]   len_cur;
  logic                last_slot;
  logic                last_read;

  assign soft_clear = sync[4];
  assign rec_btn    = sync[3];
  assign play_btn   = sync[2];
  assign clip_wr    = sync[1];
  assign clip_rd    = sync[0];

  assign rec_edge   = rec_btn & ~prev_rec;
  assign play_edge  = play_btn & ~prev_play;

  assign offset_next = {1'b0, offset} + {{OFFSET_W{1'b0}}, 1'b1};
  assign len_entry   = clip_rd ? len[1] : len[0];
  assign len_cur     = cur_clip ? len[1] : len[0];
  assign last_slot   = &offset;
  assign last_read   = (offset_next == len_cur);

  // Edge history keeps tracking the buttons even during soft reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_rec  <= 1'b0;
      prev_play <= 1'b0;
    end else begin
      prev_rec  <= rec_btn;
      prev_play <= play_btn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_clip  <= 1'b0;
      offset    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else if (soft_clear) begin
      state     <= IDLE;
      cur_clip  <= 1'b0;
      offset    <= '0;
      len[0]    <= '0;
      len[1]    <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      recording <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      done   <= 1'b0;

      case (state)
        IDLE: begin
          if (rec_edge) begin
            state         <= REC;
            recording     <= 1'b1;
            cur_clip      <= clip_wr;
            offset        <= '0;
            len[clip_wr]  <= '0;
          end else if (play_edge) begin
            if (len_entry != '0) begin
              state    <= PLAY;
              playing  <= 1'b1;
              cur_clip <= clip_rd;
              offset   <= '0;
            end else begin
              done <= 1'b1;
            end
          end
        end

        // A stop press outranks a coincident tick: no write that cycle.
        REC: begin
          if (rec_edge) begin
            state     <= IDLE;
            recording <= 1'b0;
            done      <= 1'b1;
          end else if (sample_tick) begin
            mem_we        <= 1'b1;
            mem_addr      <= {cur_clip, offset};
            len[cur_clip] <= offset_next;
            if (last_slot) begin
              state     <= IDLE;
              recording <= 1'b0;
              done      <= 1'b1;
            end else begin
              offset <= offset + 1'b1;
            end
          end
        end

        PLAY: begin
          if (play_edge) begin
            state   <= IDLE;
            playing <= 1'b0;
            done    <= 1'b1;
          end else if (sample_tick) begin
            mem_re   <= 1'b1;
            mem_addr <= {cur_clip, offset};
            if (last_read) begin
              state   <= IDLE;
              playing <= 1'b0;
              done    <= 1'b1;
            end else begin
              offset <= offset + 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          recording <= 1'b0;
          playing   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_recorder_control.sv
// +----------------------------------------------------------------------+
// | tb_recorder_control: directed vector bench for recorder_control.     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_recorder_control;

  localparam int OFFSET_W = 3;

  logic                clock;
  logic                reset;
  logic [4:0]          sync;
  logic                sample_tick;
  logic [OFFSET_W:0]   mem_addr;
  logic                mem_we;
  logic                mem_re;
  logic                recording;
  logic                playing;
  logic                done;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [4:0] sync;
    logic       tick;
    logic [3:0] addr;
    logic       we;
    logic       re;
    logic       rec;
    logic       ply;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  recorder_control #(.OFFSET_W(OFFSET_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .sync        (sync),
    .sample_tick (sample_tick),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .recording   (recording),
    .playing     (playing),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic [4:0] s, input logic t, input logic [3:0] a,
                              input logic we, input logic re, input logic rc,
                              input logic pl, input logic dn);
    vec_t v;
    v.sync = s; v.tick = t; v.addr = a; v.we = we; v.re = re;
    v.rec = rc; v.ply = pl; v.done = dn;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [3:0] a, input logic we,
                       input logic re, input logic rc, input logic pl, input logic dn);
    compared++;
    if ({mem_addr, mem_we, mem_re, recording, playing, done} !== {a, we, re, rc, pl, dn}) begin
      mismatched++;
      $display("FAIL %s: got addr=%0d we=%b re=%b rec=%b play=%b done=%b, expected addr=%0d we=%b re=%b rec=%b play=%b done=%b",
               name, mem_addr, mem_we, mem_re, recording, playing, done, a, we, re, rc, pl, dn);
    end
  endtask

  task automatic apply(input logic [4:0] s, input logic t);
    @(negedge clock);
    sync = s;
    sample_tick = t;
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Power-up and idle checks, empty-clip play press.
    add(5'b10000, 0, 0, 0, 0, 0, 0, 0);
    add(5'b10000, 0, 0, 0, 0, 0, 0, 0);
    add(5'b10000, 0, 0, 0, 0, 0, 0, 0);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0);
    add(5'b00100, 0, 0, 0, 0, 0, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0);
    // Record five samples into clip 1, then stop.
    add(5'b01010, 0, 0, 0, 0, 1, 0, 0);
    add(5'b00010, 1, 8, 1, 0, 1, 0, 0);
    add(5'b00000, 1, 9, 1, 0, 1, 0, 0);
    add(5'b00000, 0, 9, 0, 0, 1, 0, 0);
    add(5'b00000, 1, 10, 1, 0, 1, 0, 0);
    add(5'b00000, 1, 11, 1, 0, 1, 0, 0);
    add(5'b00000, 1, 12, 1, 0, 1, 0, 0);
    add(5'b00000, 0, 12, 0, 0, 1, 0, 0);
    add(5'b01000, 0, 12, 0, 0, 0, 0, 1);
    add(5'b00000, 0, 12, 0, 0, 0, 0, 0);
    // Play back clip 1 to its recorded end.
    add(5'b00101, 0, 12, 0, 0, 0, 1, 0);
    add(5'b00000, 1, 8, 0, 1, 0, 1, 0);
    add(5'b00000, 1, 9, 0, 1, 0, 1, 0);
    add(5'b00000, 0, 9, 0, 0, 0, 1, 0);
    add(5'b00000, 1, 10, 0, 1, 0, 1, 0);
    add(5'b00000, 1, 11, 0, 1, 0, 1, 0);
    add(5'b00000, 1, 12, 0, 1, 0, 0, 1);
    add(5'b00000, 1, 12, 0, 0, 0, 0, 0);
    // Record clip 0 until full; extra ticks are ignored.
    add(5'b01000, 0, 12, 0, 0, 1, 0, 0);
    for (int i = 0; i < 8; i++) add(5'b00000, 1, 4'(i), 1, 0, i != 7, 0, i == 7);
    add(5'b00000, 1, 7, 0, 0, 0, 0, 0);
    add(5'b00000, 1, 7, 0, 0, 0, 0, 0);
    // Full-length playback of clip 0.
    add(5'b00100, 0, 7, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) add(5'b00000, 1, 4'(i), 0, 1, 0, i != 7, i == 7);
    // Simultaneous presses, ignored play in REC, stop coincident with tick.
    add(5'b01100, 0, 7, 0, 0, 1, 0, 0);
    add(5'b00000, 1, 0, 1, 0, 1, 0, 0);
    add(5'b00100, 0, 0, 0, 0, 1, 0, 0);
    add(5'b00000, 0, 0, 0, 0, 1, 0, 0);
    add(5'b01000, 1, 0, 0, 0, 0, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0);
    // Clip 0 now holds exactly one sample.
    add(5'b00100, 0, 0, 0, 0, 0, 1, 0);
    add(5'b00000, 1, 0, 0, 1, 0, 0, 1);
    add(5'b00000, 0, 0, 0, 0, 0, 0, 0);

    reset = 1'b0;
    sync = 5'b00000;
    sample_tick = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].sync, vecs[i].tick);
      check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].we, vecs[i].re,
            vecs[i].rec, vecs[i].ply, vecs[i].done);
    end

    // Async reset in the middle of a clip 1 playback.
    apply(5'b00101, 0);
    check("arst_play_start", 0, 0, 0, 0, 1, 0);
    apply(5'b00000, 1);
    check("arst_first_read", 8, 0, 1, 0, 1, 0);
    @(negedge clock);
    sample_tick = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("arst_immediate", 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    check("arst_held", 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    sample_tick = 1'b0;
    apply(5'b00101, 0);
    check("arst_len1_cleared", 0, 0, 0, 0, 0, 1);
    apply(5'b00000, 0);
    check("arst_idle", 0, 0, 0, 0, 0, 0);
    apply(5'b00100, 0);
    check("arst_len0_cleared", 0, 0, 0, 0, 0, 1);

    // Soft reset in the middle of a clip 1 recording.
    apply(5'b01010, 0);
    check("srst_rec_start", 0, 0, 0, 1, 0, 0);
    apply(5'b00000, 1);
    check("srst_first_write", 8, 1, 0, 1, 0, 0);
    apply(5'b10000, 1);
    check("srst_clear", 0, 0, 0, 0, 0, 0);
    apply(5'b00000, 0);
    check("srst_idle", 0, 0, 0, 0, 0, 0);
    apply(5'b00101, 0);
    check("srst_len1_cleared", 0, 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
